uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver for the host link: 5-9 data bits, optional odd/even parity, 1-2 stop bits.
//  Has an internal oversample tick, a sync+majority filter and per-frame parity/framing/break status.

---
 rtl/uart_rx_cfg_if.sv | 29 ++
 rtl/uart_rx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// UART receiver port bundle: serial input plus decoded word and status.
// master = receiver side, slave = consumer/line-driver side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 rx_busy;
  logic                 rx_idle;
  logic                 rx_eop;

  modport master (
    input  rxd,
    output data, data_valid, parity_err,
    output frame_err, break_det,
    output rx_busy, rx_idle, rx_eop
  );

  modport slave (
    output rxd,
    input  data, data_valid, parity_err,
    input  frame_err, break_det,
    input  rx_busy, rx_idle, rx_eop
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled, majority-filtered, with
// parity/framing/break status and idle / end-of-packet detection.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_cfg_if.master bus
);
  localparam int BRATE = BAUD * OVERSAMPLE;
  localparam int DIV   = (CLK_FREQ + BRATE / 2) / BRATE;
  localparam int DW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OSW   = $clog2(OVERSAMPLE);
  localparam int GMAX  = GAP_BITS * OVERSAMPLE;
  localparam int GW    = $clog2(GMAX + 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_cfg: clock divider must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_q;
  logic [1:0]           sync_q;
  logic [2:0]           win_q;
  logic [OSW-1:0]       os_q, os_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 stop1_q, stop1_d;
  logic                 ferr_q, ferr_d;
  logic                 dv_q, dv_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 brk_q, brk_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 armed_q, armed_d;
  logic                 eop_q, eop_d;
  logic                 tick, rx_bit;
  logic                 mid_start, mid, all_zero;

  assign tick   = (div_q == '0);
  assign rx_bit = (win_q[0] & win_q[1]) |
                  (win_q[0] & win_q[2]) |
                  (win_q[1] & win_q[2]);

  assign mid_start = tick &&
    (os_q == OSW'(OVERSAMPLE / 2 - 1));
  assign mid = tick && (os_q == OSW'(OVERSAMPLE - 1));

  // break = every sampled bit of the frame, stop bits included, was 0
  assign all_zero = (shr_q == '0) &&
    ((PARITY == 0) || !par_q) &&
    !stop1_q && !rx_bit;

  always_comb begin
    state_d = state_q;
    os_d    = tick ? os_q + 1'b1 : os_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    par_d   = par_q;
    stop1_d = stop1_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    brk_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick && !rx_bit) state_d = S_START;
      end
      S_START: begin
        if (mid_start) state_d = rx_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid) begin
          shr_d = {rx_bit, shr_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1))
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else
            bit_d = bit_q + 1'b1;
        end
      end
      S_PAR: begin
        if (mid) begin
          par_d   = rx_bit;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (all_zero) begin
              brk_d   = 1'b1;
              state_d = S_BRK;
            end else begin
              dv_d    = 1'b1;
              data_d  = shr_q;
              pe_d    = (PARITY != 0) &&
                (((^shr_q) ^ par_q) != (PARITY == 1));
              fe_d    = ferr_q | !rx_bit;
              state_d = S_IDLE;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            ferr_d  = ferr_q | !rx_bit;
            stop1_d = stop1_q | rx_bit;
          end
        end
      end
      S_BRK: begin
        if (tick && rx_bit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      os_d  = '0;
      bit_d = '0;
    end
    if (state_q == S_IDLE && state_d == S_START) begin
      ferr_d  = 1'b0;
      stop1_d = 1'b0;
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (state_q != S_IDLE || state_d != S_IDLE)
      gap_d = '0;
    else if (tick && gap_q != GW'(GMAX))
      gap_d = gap_q + 1'b1;
    eop_d   = armed_q && (gap_q != GW'(GMAX)) &&
              (gap_d == GW'(GMAX));
    armed_d = (armed_q | dv_q | brk_q) & ~eop_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      sync_q  <= 2'b11;
      win_q   <= 3'b111;
      state_q <= S_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      stop1_q <= 1'b0;
      ferr_q  <= 1'b0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      gap_q   <= '0;
      armed_q <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      div_q   <= tick ? DW'(DIV - 1) : div_q - 1'b1;
      sync_q  <= {sync_q[0], bus.rxd};
      if (tick) win_q <= {win_q[1:0], sync_q[1]};
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      data_q  <= data_d;
      par_q   <= par_d;
      stop1_q <= stop1_d;
      ferr_q  <= ferr_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      gap_q   <= gap_d;
      armed_q <= armed_d;
      eop_q   <= eop_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.break_det  = brk_q;
  assign bus.rx_busy    = (state_q != S_IDLE);
  assign bus.rx_idle    = (gap_q == GW'(GMAX));
  assign bus.rx_eop     = eop_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) fed from
// bench-built frames and compared against a frame-level model.
module tb_uart_rx_cfg;
  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxl;
  int         nchk, nerr;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) u0 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) u1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) u2 ();

  assign u0.rxd = rxl[0];
  assign u1.rxd = rxl[1];
  assign u2.rxd = rxl[2];

  uart_rx_cfg #(
    .CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(2)
  ) d0 (.clk(clk), .rst_n(rst_n), .bus(u0.master));

  uart_rx_cfg #(
    .CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .GAP_BITS(2)
  ) d1 (.clk(clk), .rst_n(rst_n), .bus(u1.master));

  uart_rx_cfg #(
    .CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .GAP_BITS(2)
  ) d2 (.clk(clk), .rst_n(rst_n), .bus(u2.master));

  logic [8:0] dat[3];
  logic dv[3], pe[3], fe[3], bk[3];
  logic bsy[3], idl[3], ep[3];

  assign dat[0] = {1'b0, u0.data};
  assign dat[1] = {2'b0, u1.data};
  assign dat[2] = {1'b0, u2.data};
  assign dv[0] = u0.data_valid;
  assign dv[1] = u1.data_valid;
  assign dv[2] = u2.data_valid;
  assign pe[0] = u0.parity_err;
  assign pe[1] = u1.parity_err;
  assign pe[2] = u2.parity_err;
  assign fe[0] = u0.frame_err;
  assign fe[1] = u1.frame_err;
  assign fe[2] = u2.frame_err;
  assign bk[0] = u0.break_det;
  assign bk[1] = u1.break_det;
  assign bk[2] = u2.break_det;
  assign bsy[0] = u0.rx_busy;
  assign bsy[1] = u1.rx_busy;
  assign bsy[2] = u2.rx_busy;
  assign idl[0] = u0.rx_idle;
  assign idl[1] = u1.rx_idle;
  assign idl[2] = u2.rx_idle;
  assign ep[0] = u0.rx_eop;
  assign ep[1] = u1.rx_eop;
  assign ep[2] = u2.rx_eop;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t q0[$], q1[$], q2[$];
  int  brk_n[3], eop_n[3];
  int  eop_noidle, qual_bad;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ev_t e;
      e.d = dat[i];
      e.pe = pe[i];
      e.fe = fe[i];
      if (dv[i] === 1'b1) begin
        case (i)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
      if (dv[i] !== 1'b1 && (pe[i] === 1'b1 || fe[i] === 1'b1))
        qual_bad++;
      if (bk[i] === 1'b1) brk_n[i]++;
      if (ep[i] === 1'b1) begin
        eop_n[i]++;
        if (idl[i] !== 1'b1) eop_noidle++;
      end
    end
  end

  // frame format of each receiver
  function automatic int db(input int s);
    return (s == 1) ? 7 : 8;
  endfunction
  function automatic int pm(input int s);
    return (s == 1) ? 2 : 0;
  endfunction
  function automatic int sb(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  function automatic logic [15:0] mk(
    input int s, input logic [8:0] d,
    input logic p, input logic [1:0] st,
    output int n);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < db(s); i++) begin
      f[k] = d[i];
      k++;
    end
    if (pm(s) != 0) begin
      f[k] = p;
      k++;
    end
    for (int i = 0; i < sb(s); i++) begin
      f[k] = st[i];
      k++;
    end
    n = k;
    return f;
  endfunction

  // reference: parity by counting ones, framing by any low stop bit
  function automatic ev_t model(
    input int s, input logic [8:0] d,
    input logic p, input logic [1:0] st);
    ev_t e;
    int ones;
    ones = 0;
    e.d = '0;
    for (int i = 0; i < db(s); i++) begin
      e.d[i] = d[i];
      ones += int'(d[i]);
    end
    ones += int'(p);
    if (pm(s) == 0) e.pe = 1'b0;
    else if (pm(s) == 1) e.pe = (ones % 2) == 0;
    else e.pe = (ones % 2) == 1;
    e.fe = 1'b0;
    for (int i = 0; i < sb(s); i++)
      if (!st[i]) e.fe = 1'b1;
    return e;
  endfunction

  function automatic ev_t get(input int s, input int k);
    ev_t e;
    e = '1;
    case (s)
      0: if (k < q0.size()) e = q0[k];
      1: if (k < q1.size()) e = q1[k];
      default: if (k < q2.size()) e = q2[k];
    endcase
    return e;
  endfunction

  function automatic int qsz(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    q0.delete();
    q1.delete();
    q2.delete();
    brk_n = '{default: 0};
    eop_n = '{default: 0};
  endtask

  task automatic send(
    input int s, input logic [15:0] fr, input int n,
    input int last_clk, input int spike);
    for (int i = 0; i < n; i++) begin
      if (i == spike) begin
        rxl[s] = 1'b1;
        wclk(75);
        rxl[s] = 1'b0;
        wclk(10);
        rxl[s] = 1'b1;
        wclk(75);
      end else begin
        rxl[s] = fr[i];
        wclk((i == n - 1) ? last_clk : BIT);
      end
    end
    rxl[s] = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] v;
      v = {dat[i], dv[i], pe[i], fe[i], bk[i],
           bsy[i], idl[i], ep[i]};
      nchk++;
      if (v !== '0) begin
        nerr++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", i, v);
      end
    end
    rst_n = 1'b1;
    wclk(3 * BIT);
    nchk++;
    if (idl[0] !== 1'b1) begin
      nerr++;
      $display("FAIL reset_idle: got %b want 1", idl[0]);
    end
    nchk++;
    if (eop_n[0] !== 0) begin
      nerr++;
      $display("FAIL reset_no_eop: got %0d want 0", eop_n[0]);
    end
  endtask

  task automatic test_basic();
    logic [15:0] fr;
    int n;
    ev_t ex;
    clr();
    fr = mk(0, 9'h0A5, 1'b0, 2'b11, n);
    ex = model(0, 9'h0A5, 1'b0, 2'b11);
    send(0, fr, n, BIT, -1);
    wclk(4 * BIT);
    nchk++;
    if (qsz(0) !== 1) begin
      nerr++;
      $display("FAIL basic_count: got %0d want 1", qsz(0));
    end
    nchk++;
    if (get(0, 0) !== ex) begin
      nerr++;
      $display("FAIL basic_word: got %h want %h", get(0, 0), ex);
    end
    nchk++;
    if (eop_n[0] !== 1) begin
      nerr++;
      $display("FAIL basic_eop: got %0d want 1", eop_n[0]);
    end
  endtask

  task automatic test_random_8n1();
    ev_t exq[$];
    logic [15:0] fr;
    logic [8:0] d;
    int n;
    clr();
    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom_range(0, 255));
      fr = mk(0, d, 1'b0, 2'b11, n);
      exq.push_back(model(0, d, 1'b0, 2'b11));
      send(0, fr, n, BIT + $urandom_range(0, BIT), -1);
    end
    wclk(4 * BIT);
    nchk++;
    if (qsz(0) !== 5) begin
      nerr++;
      $display("FAIL rnd8n1_count: got %0d want 5", qsz(0));
    end
    for (int k = 0; k < 5; k++) begin
      nchk++;
      if (get(0, k) !== exq[k]) begin
        nerr++;
        $display("FAIL rnd8n1_word%0d: got %h want %h",
                 k, get(0, k), exq[k]);
      end
    end
    nchk++;
    if (eop_n[0] !== 1) begin
      nerr++;
      $display("FAIL rnd8n1_eop: got %0d want 1", eop_n[0]);
    end
  endtask

  task automatic test_parity();
    ev_t exq[$];
    logic [15:0] fr;
    logic [8:0] d;
    logic p;
    logic [1:0] st;
    int n;
    clr();
    for (int k = 0; k < 7; k++) begin
      if (k < 2) begin
        d = 9'h035;
        p = k[0];
        st = 2'b11;
      end else begin
        d = 9'($urandom_range(1, 127));
        p = 1'($urandom_range(0, 1));
        st = {1'b1, 1'($urandom_range(0, 3) != 0)};
      end
      fr = mk(1, d, p, st, n);
      exq.push_back(model(1, d, p, st));
      send(1, fr, n, BIT, -1);
      wclk(BIT);
    end
    wclk(3 * BIT);
    nchk++;
    if (qsz(1) !== 7) begin
      nerr++;
      $display("FAIL par_count: got %0d want 7", qsz(1));
    end
    for (int k = 0; k < 7; k++) begin
      nchk++;
      if (get(1, k) !== exq[k]) begin
        nerr++;
        $display("FAIL par_word%0d: got %h want %h",
                 k, get(1, k), exq[k]);
      end
    end
  endtask

  task automatic test_stop2();
    ev_t exq[$];
    logic [15:0] fr;
    logic [8:0] d;
    logic [1:0] st;
    int n;
    clr();
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 9'h03C : 9'($urandom_range(1, 255));
      case (k)
        0: st = 2'b01;
        1: st = 2'b10;
        2: st = 2'b11;
        default: st = 2'b00;
      endcase
      fr = mk(2, d, 1'b0, st, n);
      exq.push_back(model(2, d, 1'b0, st));
      send(2, fr, n, BIT, -1);
      wclk(BIT);
    end
    wclk(3 * BIT);
    nchk++;
    if (qsz(2) !== 4) begin
      nerr++;
      $display("FAIL stop2_count: got %0d want 4", qsz(2));
    end
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (get(2, k) !== exq[k]) begin
        nerr++;
        $display("FAIL stop2_word%0d: got %h want %h",
                 k, get(2, k), exq[k]);
      end
    end
  endtask

  task automatic test_break();
    logic [15:0] fr;
    int n;
    ev_t ex;
    clr();
    rxl[0] = 1'b0;
    wclk(20 * BIT);
    rxl[0] = 1'b1;
    wclk(2 * BIT);
    nchk++;
    if (brk_n[0] !== 1) begin
      nerr++;
      $display("FAIL brk_count: got %0d want 1", brk_n[0]);
    end
    nchk++;
    if (qsz(0) !== 0) begin
      nerr++;
      $display("FAIL brk_no_data: got %0d want 0", qsz(0));
    end
    fr = mk(0, 9'h055, 1'b0, 2'b11, n);
    ex = model(0, 9'h055, 1'b0, 2'b11);
    send(0, fr, n, BIT, -1);
    wclk(4 * BIT);
    nchk++;
    if (get(0, 0) !== ex || qsz(0) !== 1) begin
      nerr++;
      $display("FAIL brk_after: got %h n=%0d want %h n=1",
               get(0, 0), qsz(0), ex);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] fr;
    int n;
    ev_t ex;
    clr();
    rxl[0] = 1'b0;
    wclk(30);
    rxl[0] = 1'b1;
    wclk(BIT - 30);
    nchk++;
    if (bsy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL glitch_busy: got %b want 0", bsy[0]);
    end
    wclk(BIT);
    nchk++;
    if (qsz(0) !== 0 || brk_n[0] !== 0) begin
      nerr++;
      $display("FAIL glitch_quiet: got dv=%0d brk=%0d want 0 0",
               qsz(0), brk_n[0]);
    end
    fr = mk(0, 9'h0FF, 1'b0, 2'b11, n);
    ex = model(0, 9'h0FF, 1'b0, 2'b11);
    send(0, fr, n, BIT, 4);
    wclk(4 * BIT);
    nchk++;
    if (get(0, 0) !== ex || qsz(0) !== 1) begin
      nerr++;
      $display("FAIL spike_word: got %h n=%0d want %h n=1",
               get(0, 0), qsz(0), ex);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fr;
    int n;
    clr();
    for (int k = 1; k <= 3; k++) begin
      fr = mk(0, 9'(k), 1'b0, 2'b11, n);
      send(0, fr, n, BIT + BIT / 2, -1);
    end
    wclk(4 * BIT);
    nchk++;
    if (qsz(0) !== 3) begin
      nerr++;
      $display("FAIL b2b_count: got %0d want 3", qsz(0));
    end
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (get(0, k) !== model(0, 9'(k + 1), 1'b0, 2'b11)) begin
        nerr++;
        $display("FAIL b2b_word%0d: got %h want %0d",
                 k, get(0, k), k + 1);
      end
    end
    nchk++;
    if (eop_n[0] !== 1) begin
      nerr++;
      $display("FAIL b2b_eop: got %0d want 1", eop_n[0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] fr;
    logic [15:0] v;
    int n;
    ev_t ex;
    clr();
    fr = mk(0, 9'h001, 1'b0, 2'b11, n);
    send(0, fr, n, BIT + BIT / 2, -1);
    fr = mk(0, 9'h002, 1'b0, 2'b11, n);
    send(0, fr, 5, BIT, -1);
    rst_n = 1'b0;
    wclk(2);
    v = {dat[0], dv[0], pe[0], fe[0], bk[0], bsy[0], idl[0], ep[0]};
    nchk++;
    if (v !== '0) begin
      nerr++;
      $display("FAIL rstmid_outputs: got %h want 0", v);
    end
    wclk(3);
    rst_n = 1'b1;
    wclk(3 * BIT);
    nchk++;
    if (qsz(0) !== 1 || get(0, 0).d !== 9'h001) begin
      nerr++;
      $display("FAIL rstmid_no_partial: got n=%0d d=%h want 1 001",
               qsz(0), get(0, 0).d);
    end
    nchk++;
    if (eop_n[0] !== 0 || idl[0] !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_idle: got eop=%0d idle=%b want 0 1",
               eop_n[0], idl[0]);
    end
    fr = mk(0, 9'h05A, 1'b0, 2'b11, n);
    ex = model(0, 9'h05A, 1'b0, 2'b11);
    send(0, fr, n, BIT, -1);
    wclk(4 * BIT);
    nchk++;
    if (get(0, 1) !== ex || qsz(0) !== 2) begin
      nerr++;
      $display("FAIL rstmid_next: got %h n=%0d want %h n=2",
               get(0, 1), qsz(0), ex);
    end
  endtask

  task automatic test_qualifiers();
    nchk++;
    if (qual_bad !== 0) begin
      nerr++;
      $display("FAIL qual_without_valid: got %0d want 0", qual_bad);
    end
    nchk++;
    if (eop_noidle !== 0) begin
      nerr++;
      $display("FAIL eop_without_idle: got %0d want 0", eop_noidle);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    eop_noidle = 0;
    qual_bad = 0;
    rst_n = 1'b0;
    rxl = '1;
    clr();
    wclk(4);
    test_reset();
    test_basic();
    test_random_8n1();
    test_parity();
    test_stop2();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_qualifiers();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
